// File: rtl/gf_mult_seq_ctrl.sv
// rtl/gf_mult_seq_ctrl.sv - sequencer for a digit-serial systolic GF(2^M) multiplier array
module gf_mult_seq_ctrl #(
    parameter int M       = 16,
    parameter int D       = 4,
    parameter int ARR_LAT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a_in,
    input  logic [M-1:0] b_in,
    input  logic [M-1:0] g_in,
    output logic [M-1:0] arr_a,
    output logic [M-1:0] arr_g,
    output logic [D-1:0] arr_b,
    output logic         arr_t,
    output logic         arr_en,
    input  logic [M-1:0] arr_p,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] p_out,
    output logic         busy
);
    localparam int N  = M / D;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int LW = (ARR_LAT > 1) ? $clog2(ARR_LAT) : 1;
    localparam logic [CW-1:0] DIG_LAST = CW'(N - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(ARR_LAT - 1);

    generate
        if (M % D != 0) begin : g_bad_digit
            $error("gf_mult_seq_ctrl: M must be a multiple of D");
        end
        if (ARR_LAT < 1) begin : g_bad_lat
            $error("gf_mult_seq_ctrl: ARR_LAT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [M-1:0]  a_q, a_d;
    logic [M-1:0]  b_q, b_d;
    logic [M-1:0]  g_q, g_d;
    logic [M-1:0]  p_q, p_d;
    logic [CW-1:0] dig_cnt_q, dig_cnt_d;
    logic [LW-1:0] lat_cnt_q, lat_cnt_d;
    logic          accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = S_FEED;
            S_FEED:  if (dig_cnt_q == DIG_LAST) state_d = S_DRAIN;
            S_DRAIN: if (lat_cnt_q == LAT_LAST) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = in_valid ? S_FEED : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // MSB digit first: digit k sits at b_q[M-1-k*D -: D]
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        arr_en    = 1'b0;
        arr_t     = 1'b0;
        arr_b     = '0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_FEED: begin
                arr_en = 1'b1;
                arr_t  = (dig_cnt_q == '0);
                arr_b  = b_q[M-1-int'(dig_cnt_q)*D -: D];
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        g_d       = g_q;
        p_d       = p_q;
        dig_cnt_d = dig_cnt_q;
        lat_cnt_d = lat_cnt_q;
        if (state_q == S_FEED) begin
            dig_cnt_d = dig_cnt_q + 1'b1;
            if (dig_cnt_q == DIG_LAST) lat_cnt_d = '0;
        end
        if (state_q == S_DRAIN) begin
            lat_cnt_d = lat_cnt_q + 1'b1;
            if (lat_cnt_q == LAT_LAST) p_d = arr_p;
        end
        if (accept) begin
            a_d       = a_in;
            b_d       = b_in;
            g_d       = g_in;
            dig_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            g_q       <= '0;
            p_q       <= '0;
            dig_cnt_q <= '0;
            lat_cnt_q <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            g_q       <= g_d;
            p_q       <= p_d;
            dig_cnt_q <= dig_cnt_d;
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign arr_a = a_q;
    assign arr_g = g_q;
    assign p_out = p_q;

endmodule

// File: tb/tb_gf_mult_seq_ctrl.sv
// tb/tb_gf_mult_seq_ctrl.sv - self-checking bench for gf_mult_seq_ctrl with behavioural array and GF reference
module tb_gf_mult_seq_ctrl;
    localparam int M   = 16;
    localparam int D   = 4;
    localparam int LAT = 4;
    localparam int N   = M / D;
    localparam logic [15:0] G = 16'h100B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, arr_t, arr_en, out_valid, out_ready, busy;
    logic [15:0] a_in, b_in, g_in, arr_a, arr_g, arr_p, p_out;
    logic [3:0]  arr_b;

    logic        in_valid2, in_ready2, arr_t2, arr_en2, out_valid2, out_ready2, busy2;
    logic [7:0]  a_in2, b_in2, g_in2, arr_a2, arr_g2, arr_p2, p_out2, arr_b2;

    int n_total = 0;
    int n_bad   = 0;

    gf_mult_seq_ctrl #(.M(M), .D(D), .ARR_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .g_in(g_in), .arr_a(arr_a), .arr_g(arr_g),
        .arr_b(arr_b), .arr_t(arr_t), .arr_en(arr_en), .arr_p(arr_p),
        .out_valid(out_valid), .out_ready(out_ready), .p_out(p_out), .busy(busy)
    );

    gf_mult_seq_ctrl #(.M(8), .D(8), .ARR_LAT(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a_in(a_in2), .b_in(b_in2), .g_in(g_in2), .arr_a(arr_a2), .arr_g(arr_g2),
        .arr_b(arr_b2), .arr_t(arr_t2), .arr_en(arr_en2), .arr_p(arr_p2),
        .out_valid(out_valid2), .out_ready(out_ready2), .p_out(p_out2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mulx(input logic [31:0] v, input logic [31:0] g, input int m);
        logic top;
        top = v[m-1];
        v = (v << 1) & ((32'd1 << m) - 32'd1);
        if (top) v = v ^ g;
        return v;
    endfunction

    // One systolic step: acc*x^dw + a*digit, all mod G
    function automatic logic [31:0] arr_step(input logic [31:0] acc, input logic [31:0] a,
                                             input logic [31:0] g, input logic [31:0] d,
                                             input logic t, input int m, input int dw);
        logic [31:0] r;
        r = t ? 32'd0 : acc;
        for (int j = dw - 1; j >= 0; j--) begin
            r = mulx(r, g, m);
            if (d[j]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [31:0] gf_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] g, input int m);
        logic [63:0] p;
        logic [63:0] poly;
        p = 64'd0;
        poly = (64'd1 << m) | 64'(g);
        for (int i = 0; i < m; i++) if (b[i]) p = p ^ (64'(a) << i);
        for (int i = 2 * m - 2; i >= m; i--) if (p[i]) p = p ^ (poly << (i - m));
        return p[31:0];
    endfunction

    logic [15:0] pipe1 [LAT];
    always @(posedge clk) begin
        if (arr_en) pipe1[0] <= 16'(arr_step(32'(pipe1[0]), 32'(arr_a), 32'(arr_g), 32'(arr_b), arr_t, M, D));
        for (int i = 1; i < LAT; i++) pipe1[i] <= pipe1[i-1];
    end
    assign arr_p = pipe1[LAT-1];

    logic [7:0] acc2;
    always @(posedge clk) begin
        if (arr_en2) acc2 <= 8'(arr_step(32'(acc2), 32'(arr_a2), 32'(arr_g2), 32'(arr_b2), arr_t2, 8, 8));
    end
    assign arr_p2 = acc2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            tick();
            #1;
            n++;
        end
        check({tag, "_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic run_directed(input logic [15:0] a, input logic [15:0] b, input logic [15:0] exp);
        tick();
        in_valid = 1'b1; a_in = a; b_in = b; g_in = G; out_ready = 1'b0;
        #1;
        check("in_ready_idle", 32'(in_ready), 32'd1);
        for (int k = 1; k <= N; k++) begin
            tick();
            in_valid = 1'b0;
            #1;
            check("feed_en", 32'(arr_en), 32'd1);
            check("feed_digit", 32'(arr_b), 32'((b >> (M - k * D)) & 16'h000F));
            check("feed_tag", 32'(arr_t), 32'(k == 1));
            check("feed_arr_a", 32'(arr_a), 32'(a));
        end
        for (int k = 1; k <= LAT; k++) begin
            tick();
            #1;
            check("drain_en", 32'(arr_en), 32'd0);
            check("drain_out_valid", 32'(out_valid), 32'd0);
        end
        tick();
        #1;
        check("done_out_valid", 32'(out_valid), 32'd1);
        check("done_p_out", 32'(p_out), 32'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        check("done_drop", 32'(out_valid), 32'd0);
        check("back_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int ghost;
        int sent, recv, cyc;
        logic [15:0] ra, rb;
        logic [15:0] exp_q[$];

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; g_in = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b0; a_in2 = '0; b_in2 = '0; g_in2 = '0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_arr_en", 32'(arr_en), 32'd0);
        check("rst_arr_t", 32'(arr_t), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_arr_b", 32'(arr_b), 32'd0);
        check("rst_p_out", 32'(p_out), 32'd0);
        check("rst_arr_a", 32'(arr_a), 32'd0);
        check("rst_arr_g", 32'(arr_g), 32'd0);

        run_directed(16'h0001, 16'h1234, 16'h1234);
        run_directed(16'h0002, 16'h8000, 16'h100B);

        tick();
        in_valid = 1'b1; a_in = 16'h0001; b_in = 16'h00FF; g_in = G;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
        wait_out("bp");
        check("bp_p_out", 32'(p_out), 32'h00FF);
        for (int k = 0; k < 5; k++) begin
            tick();
            in_valid = 1'b1; a_in = 16'h0003; b_in = 16'h0003; out_ready = 1'b0;
            #1;
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_p", 32'(p_out), 32'h00FF);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_no_capture", 32'(arr_a), 32'h0001);
        end
        tick();
        out_ready = 1'b1; in_valid = 1'b1;
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        #1;
        check("b2b_feed_en", 32'(arr_en), 32'd1);
        check("b2b_feed_tag", 32'(arr_t), 32'd1);
        check("b2b_valid_drop", 32'(out_valid), 32'd0);
        check("b2b_arr_a", 32'(arr_a), 32'h0003);
        wait_out("b2b");
        check("b2b_p_out", 32'(p_out), 32'h0005);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;

        tick();
        in_valid = 1'b1; a_in = 16'h1234; b_in = 16'h5678;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
        tick();
        rst = 1'b1;
        #1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_arr_en", 32'(arr_en), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_p_out", 32'(p_out), 32'd0);
        ghost = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            #1;
            if (out_valid) ghost++;
        end
        check("midrst_no_ghost", 32'(ghost), 32'd0);
        run_directed(16'h0002, 16'h0003, 16'h0006);

        sent = 0; recv = 0; cyc = 0;
        ra = 16'($urandom); rb = 16'($urandom);
        while (recv < 200 && cyc < 20000) begin
            tick();
            cyc++;
            in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
            a_in = ra; b_in = rb; g_in = G;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(16'(gf_ref(32'(ra), 32'(rb), 32'(G), M)));
                sent++;
                ra = 16'($urandom);
                rb = 16'($urandom);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("rand_extra_product", 32'd1, 32'd0);
                else check("rand_p_out", 32'(p_out), 32'(exp_q.pop_front()));
                recv++;
            end
        end
        check("rand_recv", 32'(recv), 32'd200);
        check("rand_sent", 32'(sent), 32'd200);
        in_valid = 1'b0; out_ready = 1'b0;

        tick();
        in_valid2 = 1'b1; a_in2 = 8'h57; b_in2 = 8'h83; g_in2 = 8'h1B;
        #1;
        check("m8_in_ready", 32'(in_ready2), 32'd1);
        tick();
        in_valid2 = 1'b0;
        #1;
        check("m8_feed_en", 32'(arr_en2), 32'd1);
        check("m8_feed_tag", 32'(arr_t2), 32'd1);
        check("m8_feed_digit", 32'(arr_b2), 32'h83);
        tick();
        #1;
        check("m8_drain_en", 32'(arr_en2), 32'd0);
        check("m8_drain_valid", 32'(out_valid2), 32'd0);
        tick();
        #1;
        check("m8_out_valid", 32'(out_valid2), 32'd1);
        check("m8_p_out", 32'(p_out2), 32'hC1);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        #1;
        check("m8_drop", 32'(out_valid2), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
